// File: rtl/klp_trace_pkg.sv
// Shared types and constants for the KLP32V1 trace transmitter.
// A frame is one sync byte followed by the 13 bytes of a record, least significant byte first.
package klp_trace_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         FRAME_LEN = 14;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wb;
    logic [7:0]  flags;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    BODY
  } tx_state_t;

  // Place the record so that its bytes leave the shift register in wire order.
  function automatic logic [REC_W-1:0] pack_frame(input trace_rec_t rec);
    return {rec.flags, rec.wb, rec.inst, rec.pc};
  endfunction

endpackage

// File: rtl/klp_trace_tx_fifo.sv
// Synchronous record FIFO. Pointers carry one extra wrap bit so that full and empty
// can be told apart; the caller never pushes when full unless it pops in the same cycle.
module trace_fifo
  import klp_trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  trace_rec_t  wdata,
  input  logic        pop,
  output trace_rec_t  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  trace_rec_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/klp_trace_tx.sv
// Captures KLP32V1 debug-port records into a FIFO and sends each one as a 14-byte
// frame (A5 sync + pc, inst, writeBack little-endian + flags) on a valid/ready byte stream.
module klp_trace_tx
  import klp_trace_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int DROP_W = 16,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_capture_en,
  input  logic              i_filter,
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_inst,
  input  logic [31:0]       i_writeBack,
  input  logic              i_BrEq,
  input  logic              i_BrLT,
  input  logic              i_RegWEn,
  input  logic              i_memRW,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [LW-1:0]     o_level,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 2);

  logic              want_push;
  logic              push_ok;
  logic              drop_evt;
  logic              pop;
  logic              shift;
  logic              full;
  logic              empty;
  logic              drop_flag;
  logic [DROP_W-1:0] drop_cnt;
  trace_rec_t        wdata;
  trace_rec_t        rdata;
  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [3:0]        idx_q;
  logic [3:0]        idx_d;
  logic [REC_W-1:0]  shreg;

  assign want_push = i_capture_en && (!i_filter || i_RegWEn || i_memRW);
  // A full FIFO still takes the record when the FSM drains its head in the same cycle.
  assign push_ok   = want_push && (!full || pop);
  assign drop_evt  = want_push && !push_ok;

  assign wdata = '{pc:    i_pc,
                   inst:  i_inst,
                   wb:    i_writeBack,
                   flags: {3'b000, drop_flag, i_memRW, i_RegWEn, i_BrLT, i_BrEq}};

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_flag <= 1'b0;
      drop_cnt  <= '0;
    end else if (drop_evt) begin
      drop_flag <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end else if (push_ok) begin
      drop_flag <= 1'b0;
    end
  end

  assign o_drop_cnt = drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop)        shreg <= pack_frame(rdata);
      else if (shift) shreg <= {8'h00, shreg[REC_W-1:8]};
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    shift      = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SYNC;
        end
      end
      SYNC: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SYNC_BYTE;
        if (i_tx_ready) begin
          state_d = BODY;
          idx_d   = '0;
        end
      end
      BODY: begin
        o_tx_valid = 1'b1;
        o_tx_data  = shreg[7:0];
        if (i_tx_ready) begin
          shift = 1'b1;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_klp_trace_tx.sv
// Bench for klp_trace_tx: directed frame scenarios plus a random phase, all compared
// cycle by cycle against a record/byte-queue model of the transmitter.
module tb_klp_trace_tx;

  localparam int DEPTH  = 4;
  localparam int DROP_W = 16;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_capture_en = 1'b0;
  logic              i_filter = 1'b0;
  logic [31:0]       i_pc = '0;
  logic [31:0]       i_inst = '0;
  logic [31:0]       i_writeBack = '0;
  logic              i_BrEq = 1'b0;
  logic              i_BrLT = 1'b0;
  logic              i_RegWEn = 1'b0;
  logic              i_memRW = 1'b0;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready = 1'b1;
  logic [LW-1:0]     o_level;
  logic [DROP_W-1:0] o_drop_cnt;

  klp_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_capture_en (i_capture_en),
    .i_filter     (i_filter),
    .i_pc         (i_pc),
    .i_inst       (i_inst),
    .i_writeBack  (i_writeBack),
    .i_BrEq       (i_BrEq),
    .i_BrLT       (i_BrLT),
    .i_RegWEn     (i_RegWEn),
    .i_memRW      (i_memRW),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_level      (o_level),
    .o_drop_cnt   (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_valid = -1;
  logic [7:0] tx_log [$];
  logic [7:0] exp1 [14] = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00,
                            8'hA0, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h04};

  // Reference model: queued records, bytes of the frame in flight, sticky drop, drop count.
  logic [103:0] m_fifo [$];
  logic [7:0]   m_cur [$];
  bit           m_drop = 1'b0;
  int unsigned  m_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_step();
    logic [103:0] r;
    logic [31:0]  w;
    bit           pop;
    bit           want;
    if (!reset) begin
      m_fifo.delete();
      m_cur.delete();
      m_drop = 1'b0;
      m_cnt  = 0;
      return;
    end
    pop  = (m_cur.size() == 0) && (m_fifo.size() > 0);
    if (m_cur.size() > 0 && i_tx_ready) void'(m_cur.pop_front());
    want = i_capture_en && (!i_filter || i_RegWEn || i_memRW);
    if (pop) begin
      r = m_fifo.pop_front();
      m_cur.push_back(8'hA5);
      for (int f = 0; f < 3; f++) begin
        w = r[103 - 32*f -: 32];
        for (int b = 0; b < 4; b++) m_cur.push_back(w[8*b +: 8]);
      end
      m_cur.push_back(r[7:0]);
    end
    if (want) begin
      if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back({i_pc, i_inst, i_writeBack,
                          3'b000, m_drop, i_memRW, i_RegWEn, i_BrLT, i_BrEq});
        m_drop = 1'b0;
      end else begin
        m_drop = 1'b1;
        if (m_cnt < (1 << DROP_W) - 1) m_cnt++;
      end
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    check_eq("valid", o_tx_valid, m_cur.size() > 0);
    if (m_cur.size() > 0) check_eq("data", o_tx_data, m_cur[0]);
    check_eq("level", o_level, m_fifo.size());
    check_eq("drop_cnt", o_drop_cnt, m_cnt);
    if (o_tx_valid === 1'b1 && i_tx_ready) tx_log.push_back(o_tx_data);
    if (o_tx_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic drain(input int max, input bit bp);
    int k = 0;
    while ((m_cur.size() > 0 || m_fifo.size() > 0) && k < max) begin
      i_tx_ready = bp ? (k % 3 == 0) : 1'b1;
      cycle();
      k++;
    end
    check_eq("drain_busy", (m_cur.size() > 0 || m_fifo.size() > 0), 0);
    i_tx_ready = 1'b1;
    cycle();
  endtask

  task automatic frame_test(input string tag, input bit bp);
    int n;
    tx_log.delete();
    first_valid  = -1;
    i_tx_ready   = 1'b1;
    i_capture_en = 1'b1;
    i_filter     = 1'b0;
    i_pc         = 32'h0000_0010;
    i_inst       = 32'h00A0_0093;
    i_writeBack  = 32'h0000_000A;
    i_RegWEn     = 1'b1;
    i_memRW      = 1'b0;
    i_BrEq       = 1'b0;
    i_BrLT       = 1'b0;
    n = cyc;
    cycle();
    i_capture_en = 1'b0;
    i_RegWEn     = 1'b0;
    drain(80, bp);
    check_eq({tag, "_first_valid"}, first_valid, n + 2);
    check_eq({tag, "_len"}, tx_log.size(), 14);
    for (int i = 0; i < 14; i++)
      if (i < tx_log.size()) check_eq($sformatf("%s_byte%0d", tag, i), tx_log[i], exp1[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", o_tx_valid, 0);
    check_eq("rst_data", o_tx_data, 8'h00);
    check_eq("rst_level", o_level, 0);
    check_eq("rst_drop", o_drop_cnt, 0);
    reset = 1'b1;
    cycle();

    frame_test("single", 1'b0);
    frame_test("bp", 1'b1);

    // Filter: only the memRW cycle qualifies.
    tx_log.delete();
    i_filter     = 1'b1;
    i_capture_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
      i_memRW = (i == 4);
      cycle();
    end
    i_capture_en = 1'b0;
    i_memRW      = 1'b0;
    i_filter     = 1'b0;
    drain(80, 1'b0);
    check_eq("filter_len", tx_log.size(), 14);
    if (tx_log.size() == 14) begin
      check_eq("filter_sync", tx_log[0], 8'hA5);
      check_eq("filter_flags", tx_log[13], 8'h08);
    end

    // Overflow: the first record is held in the serializer, four fill the FIFO, two are lost.
    tx_log.delete();
    i_tx_ready   = 1'b0;
    i_capture_en = 1'b1;
    i_RegWEn     = 1'b1;
    for (int i = 0; i < 7; i++) begin
      i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
      cycle();
    end
    i_capture_en = 1'b0;
    check_eq("ovf_level", o_level, 4);
    check_eq("ovf_drop", o_drop_cnt, 2);
    i_tx_ready = 1'b1;
    k = 0;
    while (m_cur.size() > 0 && k < 40) begin
      cycle();
      k++;
    end
    check_eq("ovf_first_frame_done", m_cur.size(), 0);
    // FSM is in IDLE popping the head while a new record arrives on a full FIFO.
    i_capture_en = 1'b1;
    i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
    cycle();
    i_capture_en = 1'b0;
    check_eq("fullpp_level", o_level, 4);
    check_eq("fullpp_drop", o_drop_cnt, 2);
    drain(200, 1'b0);
    i_capture_en = 1'b1;
    i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
    cycle();
    i_capture_en = 1'b0;
    i_RegWEn     = 1'b0;
    drain(80, 1'b0);
    check_eq("ovf_len", tx_log.size(), 7 * 14);
    for (int f = 0; f < 7; f++)
      if (tx_log.size() == 7 * 14) check_eq($sformatf("ovf_drop_bit_f%0d", f),
                                            tx_log[14*f + 13][4], (f == 5));

    // Reset in the middle of a frame body.
    i_capture_en = 1'b1;
    i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
    cycle();
    i_capture_en = 1'b0;
    k = 0;
    while (m_cur.size() != 8 && k < 40) begin
      cycle();
      k++;
    end
    check_eq("midrst_reached_idx5", m_cur.size(), 8);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check_eq("midrst_valid", o_tx_valid, 0);
    check_eq("midrst_level", o_level, 0);
    check_eq("midrst_drop", o_drop_cnt, 0);
    tx_log.delete();
    i_capture_en = 1'b1;
    i_BrEq = 1'b1;
    i_pc = $urandom; i_inst = $urandom; i_writeBack = $urandom;
    cycle();
    i_capture_en = 1'b0;
    i_BrEq = 1'b0;
    drain(80, 1'b0);
    check_eq("midrst_len", tx_log.size(), 14);
    if (tx_log.size() > 0) check_eq("midrst_sync", tx_log[0], 8'hA5);

    // Random traffic with random backpressure and filtering.
    for (int i = 0; i < 400; i++) begin
      i_capture_en = ($urandom_range(0, 2) != 0);
      i_filter     = ($urandom_range(0, 3) == 0);
      i_pc         = $urandom;
      i_inst       = $urandom;
      i_writeBack  = $urandom;
      i_BrEq       = 1'($urandom_range(0, 1));
      i_BrLT       = 1'($urandom_range(0, 1));
      i_RegWEn     = 1'($urandom_range(0, 1));
      i_memRW      = 1'($urandom_range(0, 1));
      i_tx_ready   = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_capture_en = 1'b0;
    drain(400, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
